// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencer for the 5-stage MIPS core.
// Drives the PC and pipeline-register enables/flushes for load-use stalls,
// dcache waits, taken-branch/jump flushes and halt.
// Optional build macro HAZARD_PERF_CNT_EN adds the stall/flush/dwait
// performance counters and their output ports.
module hazard_controller #(
  parameter int unsigned REGW = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNTW = 32
`endif
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            exm_dREN,
  input  logic            exm_dWEN,
  input  logic            idex_dREN,
  input  logic [REGW-1:0] idex_wsel,
  input  logic [REGW-1:0] ifid_rs,
  input  logic [REGW-1:0] ifid_rt,
  input  logic            exm_br_taken,
  input  logic            id_jump,
  input  logic            mwb_halt,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exm_en,
  output logic            mwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exm_flush,
  output logic            mwb_flush,
  output logic            halt,
  output logic [1:0]      state
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt,
  output logic [CNTW-1:0] dwait_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    DWAIT = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   halt_q;

  logic dmem_pend;
  logic lduse;

  // Raw control before reset gating.
  logic pc_r, ifid_en_r, idex_en_r, exm_en_r, mwb_en_r;
  logic ifid_fl_r, idex_fl_r, exm_fl_r, mwb_fl_r;

`ifdef HAZARD_PERF_CNT_EN
  logic ev_stall, ev_flush, ev_dwait;
`endif

  assign dmem_pend = (exm_dREN | exm_dWEN) & ~dhit;
  assign lduse     = idex_dREN & (idex_wsel != '0) &
                     ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

  // Priority decode of the current cycle's stall/flush controls and next state.
  always_comb begin
    pc_r      = 1'b1;
    ifid_en_r = 1'b1;
    idex_en_r = 1'b1;
    exm_en_r  = 1'b1;
    mwb_en_r  = 1'b1;
    ifid_fl_r = 1'b0;
    idex_fl_r = 1'b0;
    exm_fl_r  = 1'b0;
    mwb_fl_r  = 1'b0;
    state_d   = RUN;
`ifdef HAZARD_PERF_CNT_EN
    ev_stall  = 1'b0;
    ev_flush  = 1'b0;
    ev_dwait  = 1'b0;
`endif
    if (state_q == HALT || mwb_halt) begin
      // Whole pipe frozen; only reset leaves HALT.
      pc_r      = 1'b0;
      ifid_en_r = 1'b0;
      idex_en_r = 1'b0;
      exm_en_r  = 1'b0;
      mwb_en_r  = 1'b0;
      state_d   = HALT;
    end else if (dmem_pend) begin
      // Freeze upstream, bubble into MEM/WB so the access does not write back twice.
      pc_r      = 1'b0;
      ifid_en_r = 1'b0;
      idex_en_r = 1'b0;
      exm_en_r  = 1'b0;
      mwb_fl_r  = 1'b1;
      state_d   = DWAIT;
`ifdef HAZARD_PERF_CNT_EN
      ev_dwait  = 1'b1;
`endif
    end else if (exm_br_taken) begin
      ifid_fl_r = 1'b1;
      idex_fl_r = 1'b1;
      exm_fl_r  = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
      ev_flush  = 1'b1;
`endif
    end else if (lduse && state_q != LDUSE) begin
      // The compare seen in LDUSE is stale (ID/EX holds the bubble), so it is skipped there.
      pc_r      = 1'b0;
      ifid_en_r = 1'b0;
      idex_fl_r = 1'b1;
      state_d   = LDUSE;
`ifdef HAZARD_PERF_CNT_EN
      ev_stall  = 1'b1;
`endif
    end else if (id_jump) begin
      ifid_fl_r = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
      ev_flush  = 1'b1;
`endif
    end else if (!ihit) begin
      pc_r      = 1'b0;
      ifid_fl_r = 1'b1;
    end
  end

  // State and sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == HALT) halt_q <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters; events never fire in HALT so the counts freeze there.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      dwait_cnt <= '0;
    end else begin
      if (ev_stall) stall_cnt <= stall_cnt + 1'b1;
      if (ev_flush) flush_cnt <= flush_cnt + 1'b1;
      if (ev_dwait) dwait_cnt <= dwait_cnt + 1'b1;
    end
  end
`endif

  assign pc_en      = nRST & pc_r;
  assign ifid_en    = nRST & ifid_en_r;
  assign idex_en    = nRST & idex_en_r;
  assign exm_en     = nRST & exm_en_r;
  assign mwb_en     = nRST & mwb_en_r;
  assign ifid_flush = nRST & ifid_fl_r;
  assign idex_flush = nRST & idex_fl_r;
  assign exm_flush  = nRST & exm_fl_r;
  assign mwb_flush  = nRST & mwb_fl_r;
  assign halt       = halt_q;
  assign state      = state_q;

endmodule
